// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and condition evaluation for cond_unit_ex
package cond_pkg;
   typedef enum logic [3:0] {
      EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
   } cond_e;
   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;
   localparam int FLAG_W = 4;
   function automatic logic cond_eval(cond_e c, logic [FLAG_W-1:0] f);
      logic n, z, cy, v, r;
      n  = f[N_BIT];
      z  = f[Z_BIT];
      cy = f[C_BIT];
      v  = f[V_BIT];
      case (c)
         EQ:      r = z;
         NE:      r = !z;
         CS:      r = cy;
         CC:      r = !cy;
         MI:      r = n;
         PL:      r = !n;
         VS:      r = v;
         VC:      r = !v;
         HI:      r = cy && !z;
         LS:      r = !cy || z;
         GE:      r = n == v;
         LT:      r = n != v;
         GT:      r = !z && (n == v);
         LE:      r = z || (n != v);
         AL:      r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO save stack of flag words, no wrap-around
module flag_stack
   import cond_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [FLAG_W-1:0]          din,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic [FLAG_W-1:0]          top
);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [FLAG_W-1:0] mem [2**AW];
   logic [DW-1:0]     dm1;
   assign full  = depth == DW'(DEPTH);
   assign empty = depth == '0;
   assign dm1   = depth - DW'(1);
   assign top   = mem[dm1[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!reset) begin
         depth <= '0;
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else if (push && !full) begin
         mem[depth[AW-1:0]] <= din;
         depth <= depth + DW'(1);
      end else if (pop && !empty) begin
         depth <= dm1;
      end
   end
endmodule

// File: rtl/cond_unit_ex.sv
// cond_unit_ex: execute-stage flag register, condition check, strobe gating and exception flag stack
module cond_unit_ex
   import cond_pkg::*;
#(
   parameter int FLAG_GROUPS  = 2,
   parameter int SHADOW_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              valid,
   input  logic                              stall,
   input  logic                              flush,
   input  logic                              pcs,
   input  logic                              reg_w,
   input  logic                              mem_w,
   input  logic                              no_write,
   input  logic [FLAG_GROUPS-1:0]            flag_w,
   input  logic [3:0]                        cond,
   input  logic [3:0]                        alu_flags,
   input  logic                              exc_entry,
   input  logic                              exc_return,
   output logic                              pc_src,
   output logic                              reg_write,
   output logic                              mem_write,
   output logic                              cond_ex,
   output logic                              undef_cond,
   output logic [3:0]                        flags,
   output logic [$clog2(SHADOW_DEPTH+1)-1:0] stack_depth,
   output logic                              stack_err
);
   logic       go, exc_any, conflict, full, empty, do_push, do_pop, err_set;
   logic [3:0] wmask, top, flags_next;
   // group g of FLAG_GROUPS covers flag bits [4/FLAG_GROUPS*(g+1)-1 : 4/FLAG_GROUPS*g]
   for (genvar g = 0; g < 4; g++) begin : g_mask
      assign wmask[g] = flag_w[(g * FLAG_GROUPS) / 4];
   end
   assign cond_ex    = cond_eval(cond_e'(cond), flags);
   assign undef_cond = valid && cond == NV && !flush;
   assign exc_any    = exc_entry || exc_return;
   assign conflict   = exc_entry && exc_return;
   assign go         = valid && !stall && !flush && !exc_any && cond_ex;
   assign pc_src     = pcs && go;
   assign reg_write  = reg_w && go && !no_write;
   assign mem_write  = mem_w && go;
   assign do_push    = !stall && exc_entry && !exc_return && !full;
   assign do_pop     = !stall && exc_return && !exc_entry && !empty;
   assign err_set    = !stall && (conflict || (exc_entry && full) || (exc_return && empty));
   assign flags_next = do_pop ? top : go ? (alu_flags & wmask) | (flags & ~wmask) : flags;
   always_ff @(posedge clk) begin
      if (!reset) begin
         flags     <= '0;
         stack_err <= 1'b0;
      end else begin
         flags     <= flags_next;
         stack_err <= stack_err || err_set;
      end
   end
   flag_stack #(.DEPTH(SHADOW_DEPTH)) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (do_push),
      .pop   (do_pop),
      .din   (flags),
      .full  (full),
      .empty (empty),
      .depth (stack_depth),
      .top   (top)
   );
endmodule
